// File: rtl/sha_wsched_par.sv
// SHA-256 message schedule generator emitting WPC words per beat from a 16-word sliding window.
// Optional macro WSCHED_HOLD_EN enables the downstream hold (stall) input.
module sha_wsched_par #(
   parameter int WPC  = 1,
   parameter int IDXW = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [511:0]      msgIn,
   input  logic              hold,
   output logic              busy,
   output logic              wValid,
   output logic [32*WPC-1:0] wOut,
   output logic [IDXW-1:0]   wIdx,
   output logic              done
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(64 - WPC);
   localparam logic [IDXW-1:0] STEP     = IDXW'(WPC);

   function automatic logic [31:0] f_sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] f_sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   logic [0:0]        r_state;
   logic [31:0]       r_win [0:15];
   logic [32*WPC-1:0] r_wout;
   logic [IDXW-1:0]   r_idx;

   logic              w_held;
   logic              w_last;
   logic              w_done;
   logic              w_load;
   logic              w_adv;
   logic [31:0]       w_ext [0:15+WPC];
   logic [32*WPC-1:0] w_wnext;

`ifdef WSCHED_HOLD_EN
   assign w_held = hold && (r_state == RUN);
`else
   assign w_held = hold & 1'b0;
`endif

   assign w_last = (r_state == RUN) && (r_idx == LAST_IDX);
   assign w_done = w_last && !w_held;
   // A new block is taken from IDLE or on an un-held final beat (back-to-back).
   assign w_load = start && ((r_state == IDLE) || w_done);
   assign w_adv  = (r_state == RUN) && !w_held;

   // w_ext[0..15] is the window (or the fresh block); later entries chain the recurrence
   // so every word of a beat is produced in the same cycle.
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_src
         assign w_ext[gi] = w_load ? msgIn[511-32*gi -: 32] : r_win[gi];
      end
      for (gi = 0; gi < WPC; gi++) begin : g_exp
         assign w_ext[16+gi] = f_sig1(w_ext[14+gi]) + w_ext[9+gi]
                             + f_sig0(w_ext[1+gi]) + w_ext[gi];
         assign w_wnext[32*gi +: 32] = w_ext[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_wout  <= '0;
         for (int i = 0; i < 16; i++) r_win[i] <= '0;
      end else if (w_load) begin
         r_state <= RUN;
         r_idx   <= '0;
         r_wout  <= w_wnext;
         for (int i = 0; i < 16; i++) r_win[i] <= w_ext[i+WPC];
      end else if (w_adv) begin
         if (w_last) begin
            r_state <= IDLE;
         end else begin
            r_idx  <= r_idx + STEP;
            r_wout <= w_wnext;
            for (int i = 0; i < 16; i++) r_win[i] <= w_ext[i+WPC];
         end
      end
   end

   assign busy   = (r_state == RUN);
   assign wValid = (r_state == RUN);
   assign wOut   = r_wout;
   assign wIdx   = r_idx;
   assign done   = w_done;

endmodule

// File: tb/tb_sha_wsched_par.sv
// Self-checking bench for sha_wsched_par: WPC=1 and WPC=4 instances against a plain SHA-256 schedule model.
module tb_sha_wsched_par;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start1, start4, hold1, hold4;
   logic [511:0] msg1, msg4;
   logic         busy1, v1, done1, busy4, v4, done4;
   logic [31:0]  wout1;
   logic [127:0] wout4;
   logic [5:0]   idx1, idx4;

   int           n_chk = 0;
   int           n_err = 0;
   logic [31:0]  gold [64];
   logic [511:0] abc, m2;

   always #5 clk = ~clk;

   sha_wsched_par #(.WPC(1), .IDXW(6)) u1 (
      .clk(clk), .reset(rst_n), .start(start1), .msgIn(msg1), .hold(hold1),
      .busy(busy1), .wValid(v1), .wOut(wout1), .wIdx(idx1), .done(done1));

   sha_wsched_par #(.WPC(4), .IDXW(6)) u4 (
      .clk(clk), .reset(rst_n), .start(start4), .msgIn(msg4), .hold(hold4),
      .busy(busy4), .wValid(v4), .wOut(wout4), .wIdx(idx4), .done(done4));

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic gold_calc(input logic [511:0] m);
      logic [31:0] s0, s1;
      for (int i = 0; i < 16; i++) gold[i] = m[511-32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0 = rotr(gold[i-15], 7) ^ rotr(gold[i-15], 18) ^ (gold[i-15] >> 3);
         s1 = rotr(gold[i-2], 17) ^ rotr(gold[i-2], 19) ^ (gold[i-2] >> 10);
         gold[i] = s1 + gold[i-7] + s0 + gold[i-16];
      end
   endtask

   function automatic logic [511:0] rand_msg();
      logic [511:0] m;
      for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
      return m;
   endfunction

   task automatic run1(input bit issue_start, input bit b2b, input logic [511:0] nxt,
                       input int pulse_at, input int hold_at, input int rst_at, input bit is_abc);
      int t, hc, cyc;
      bit pulsed, hold_eff;
      gold_calc(msg1);
      if (issue_start) begin
         @(negedge clk);
         start1 = 1'b1;
      end
      t = 0; hc = 0; cyc = 0; pulsed = 0;
      while (t < 64) begin
         @(negedge clk);
         start1 = 1'b0;
         hold1  = 1'b0;
         cyc++;
         if (cyc > 400) begin
            chk("run1_timeout", 1, 0);
            return;
         end
         if (t == hold_at && hc < 3) begin
            hold1 = 1'b1;
            hc++;
         end
`ifdef WSCHED_HOLD_EN
         hold_eff = hold1;
`else
         hold_eff = 1'b0;
`endif
         if (t == pulse_at && !pulsed) begin
            start1 = 1'b1;
            msg1   = rand_msg();
            pulsed = 1'b1;
         end
         if (t == 63 && b2b && !hold_eff) begin
            start1 = 1'b1;
            msg1   = nxt;
         end
         #1;
         chk("valid", {127'b0, v1}, 1);
         chk("busy", {127'b0, busy1}, 1);
         chk("idx", {122'b0, idx1}, t);
         chk("wout", {96'b0, wout1}, gold[t]);
         chk("done", {127'b0, done1}, (t == 63 && !hold_eff) ? 1 : 0);
         if (is_abc && t == 16) chk("abc_w16", {96'b0, wout1}, 32'h61626380);
         if (is_abc && t == 17) chk("abc_w17", {96'b0, wout1}, 32'h000F0000);
         if (t == rst_at) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            chk("rst_busy", {127'b0, busy1}, 0);
            chk("rst_valid", {127'b0, v1}, 0);
            chk("rst_idx", {122'b0, idx1}, 0);
            chk("rst_wout", {96'b0, wout1}, 0);
            return;
         end
         if (!hold_eff) t++;
      end
      if (!b2b) begin
         @(negedge clk);
         hold1 = 1'b0;
         #1;
         chk("idle_valid", {127'b0, v1}, 0);
         chk("idle_busy", {127'b0, busy1}, 0);
         chk("idle_done", {127'b0, done1}, 0);
         chk("idle_idx", {122'b0, idx1}, 63);
         chk("idle_wout", {96'b0, wout1}, gold[63]);
      end
   endtask

   task automatic run4(input logic [511:0] m, input bit is_abc);
      gold_calc(m);
      msg4 = m;
      @(negedge clk);
      start4 = 1'b1;
      for (int b = 0; b < 16; b++) begin
         @(negedge clk);
         start4 = 1'b0;
         #1;
         chk("w4_valid", {127'b0, v4}, 1);
         chk("w4_idx", {122'b0, idx4}, 4 * b);
         for (int k = 0; k < 4; k++)
            chk("w4_lane", {96'b0, wout4[32*k +: 32]}, gold[4*b+k]);
         chk("w4_done", {127'b0, done4}, (b == 15) ? 1 : 0);
         if (is_abc && b == 4) begin
            chk("w4_abc_l0", {96'b0, wout4[31:0]}, 32'h61626380);
            chk("w4_abc_l1", {96'b0, wout4[63:32]}, 32'h000F0000);
         end
      end
      @(negedge clk);
      #1;
      chk("w4_idle_valid", {127'b0, v4}, 0);
      chk("w4_idle_idx", {122'b0, idx4}, 60);
   endtask

   initial begin
      rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; hold1 = 1'b0; hold4 = 1'b0;
      msg1 = '0; msg4 = '0;
      abc = '0;
      abc[511:480] = 32'h61626380;
      abc[31:0]    = 32'h00000018;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_busy", {127'b0, busy1}, 0);
      chk("reset_valid", {127'b0, v1}, 0);
      chk("reset_done", {127'b0, done1}, 0);
      chk("reset_idx", {122'b0, idx1}, 0);
      chk("reset_wout", {96'b0, wout1}, 0);
      chk("reset_wout4", wout4, 0);

      // Reset wins over a simultaneous start.
      @(negedge clk);
      start1 = 1'b1;
      msg1   = abc;
      @(negedge clk);
      rst_n  = 1'b1;
      start1 = 1'b0;
      #1;
      chk("rst_start_busy", {127'b0, busy1}, 0);

      // "abc" block, with a stray start at t=10 that must be ignored.
      msg1 = abc;
      run1(1, 0, '0, 10, -1, -1, 1);

      // Back-to-back: random block followed by another on the done beat.
      msg1 = rand_msg();
      m2   = rand_msg();
      run1(1, 1, m2, -1, -1, -1, 0);
      run1(0, 0, '0, -1, 20, -1, 0);

      // Reset mid-block at t=30, then a fresh start.
      msg1 = rand_msg();
      run1(1, 0, '0, -1, -1, 30, 0);
      msg1 = rand_msg();
      run1(1, 0, '0, -1, -1, -1, 0);

      run4(abc, 1);
      run4(rand_msg(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
